display_mux_scheduler: RTL



---
 rtl/display_mux_scheduler_if.sv | 32 +++
 rtl/display_mux_scheduler.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/display_mux_scheduler_if.sv
// -----------------------------------------------------------------------------
// display_mux_scheduler_if
// Bundles the switch inputs and display-side outputs of the dual 7-segment
// multiplexer so they travel as one port.
//   en           : 1 = display running, 0 = both digits dark
//   s0, s1       : nibbles for digit 0 / digit 1
//   s_sel        : latched nibble for the shared segment decoder
//   anode0/1     : common-anode enables, active-low (0 = lit)
//   digit_idx    : digit currently or last shown
//   digit_strobe : one-cycle pulse on the first cycle of each lit window
// master drives the switches and observes the display; slave is the scheduler.
// -----------------------------------------------------------------------------
interface display_mux_scheduler_if;
  logic       en;
  logic [3:0] s0;
  logic [3:0] s1;
  logic [3:0] s_sel;
  logic       anode0;
  logic       anode1;
  logic       digit_idx;
  logic       digit_strobe;

  modport master (
    output en, s0, s1,
    input  s_sel, anode0, anode1, digit_idx, digit_strobe
  );

  modport slave (
    input  en, s0, s1,
    output s_sel, anode0, anode1, digit_idx, digit_strobe
  );
endinterface

// File: rtl/display_mux_scheduler.sv
// -----------------------------------------------------------------------------
// display_mux_scheduler
// Time-multiplexes two common-anode 7-segment digits that share one segment
// decoder. A prescaled state machine lights each digit for DWELL cycles and
// keeps both anodes dark for BLANK cycles between digits to suppress ghosting.
// The digit's nibble is latched on the same edge its anode turns on, so the
// decoder input is stable for the whole lit window.
//
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : display_mux_scheduler_if.slave (en, s0, s1 in;
//              s_sel, anode0, anode1, digit_idx, digit_strobe out, all registered)
//
// Parameters: CNT_W (counter width), DWELL (1..2^CNT_W-1),
//             BLANK (0..2^CNT_W-1, 0 removes the blank states).
//
// Build option: DISPLAY_MUX_SYNC_EN -- when defined, en/s0/s1 pass through
// 2-flop synchronizers first (all input-to-output latencies grow by 2 cycles).
// -----------------------------------------------------------------------------
module display_mux_scheduler #(
  parameter int CNT_W = 16,
  parameter int DWELL = 20000,
  parameter int BLANK = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  display_mux_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, BLANK0, SHOW0, BLANK1, SHOW1} state_t;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  // Unused when BLANK == 0; clamped so the constant stays well defined.
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);

  logic       w_en;
  logic [3:0] w_s0;
  logic [3:0] w_s1;

`ifdef DISPLAY_MUX_SYNC_EN
  logic       r_en_p0, r_en_p1;
  logic [3:0] r_s0_p0, r_s0_p1;
  logic [3:0] r_s1_p0, r_s1_p1;

  // input synchronizer stages
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en_p0 <= 1'b0;
      r_en_p1 <= 1'b0;
      r_s0_p0 <= 4'h0;
      r_s0_p1 <= 4'h0;
      r_s1_p0 <= 4'h0;
      r_s1_p1 <= 4'h0;
    end else begin
      r_en_p0 <= bus.en;
      r_en_p1 <= r_en_p0;
      r_s0_p0 <= bus.s0;
      r_s0_p1 <= r_s0_p0;
      r_s1_p0 <= bus.s1;
      r_s1_p1 <= r_s1_p0;
    end
  end

  assign w_en = r_en_p1;
  assign w_s0 = r_s0_p1;
  assign w_s1 = r_s1_p1;
`else
  assign w_en = bus.en;
  assign w_s0 = bus.s0;
  assign w_s1 = bus.s1;
`endif

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_s_sel, w_s_sel_nxt;
  logic             r_anode0, w_anode0_nxt;
  logic             r_anode1, w_anode1_nxt;
  logic             r_idx, w_idx_nxt;
  logic             r_strobe, w_strobe_nxt;
  logic             w_enter0, w_enter1;

  // state and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_s_sel  <= 4'h0;
      r_anode0 <= 1'b1;
      r_anode1 <= 1'b1;
      r_idx    <= 1'b0;
      r_strobe <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_s_sel  <= w_s_sel_nxt;
      r_anode0 <= w_anode0_nxt;
      r_anode1 <= w_anode1_nxt;
      r_idx    <= w_idx_nxt;
      r_strobe <= w_strobe_nxt;
    end
  end

  // Outputs are derived from the next state so each registered output
  // lines up with the state it describes.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;

    case (r_state)
      IDLE: begin
        if (BLANK == 0) w_state_nxt = SHOW0;
        else            w_state_nxt = BLANK0;
      end
      BLANK0: begin
        if (r_cnt == BLANK_LAST) w_state_nxt = SHOW0;
        else                     w_cnt_nxt   = r_cnt + 1'b1;
      end
      SHOW0: begin
        if (r_cnt == DWELL_LAST) w_state_nxt = (BLANK == 0) ? SHOW1 : BLANK1;
        else                     w_cnt_nxt   = r_cnt + 1'b1;
      end
      BLANK1: begin
        if (r_cnt == BLANK_LAST) w_state_nxt = SHOW1;
        else                     w_cnt_nxt   = r_cnt + 1'b1;
      end
      SHOW1: begin
        if (r_cnt == DWELL_LAST) w_state_nxt = (BLANK == 0) ? SHOW0 : BLANK0;
        else                     w_cnt_nxt   = r_cnt + 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase

    // Disable wins from any state and discards a partial dwell.
    if (!w_en) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end

    // A SHOW state is never re-entered from itself, so "different before"
    // marks its first cycle even when DWELL == 1 and BLANK == 0.
    w_enter0 = (w_state_nxt == SHOW0) && (r_state != SHOW0);
    w_enter1 = (w_state_nxt == SHOW1) && (r_state != SHOW1);

    w_anode0_nxt = (w_state_nxt != SHOW0);
    w_anode1_nxt = (w_state_nxt != SHOW1);
    w_strobe_nxt = w_enter0 || w_enter1;

    w_s_sel_nxt = r_s_sel;
    w_idx_nxt   = r_idx;
    if (w_enter0) begin
      w_s_sel_nxt = w_s0;
      w_idx_nxt   = 1'b0;
    end else if (w_enter1) begin
      w_s_sel_nxt = w_s1;
      w_idx_nxt   = 1'b1;
    end
  end

  assign bus.s_sel        = r_s_sel;
  assign bus.anode0       = r_anode0;
  assign bus.anode1       = r_anode1;
  assign bus.digit_idx    = r_idx;
  assign bus.digit_strobe = r_strobe;

endmodule
